board_renderer: RTL

- Reads the 8x8 board memory that the board datapath writes: 4-bit piece codes, addressed by {y, x}.
- Draws each square as an 8x8-pixel tile on the 160x120 VGA plot interface.
- Overlays a piece glyph and an optional cursor border on each tile.
- Sits between the board RAM read port and the VGA adapter. The top-level controller pulses start after every initialize_complete or move_complete.

---
 rtl/board_renderer_if.sv | 27 ++
 rtl/board_renderer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/board_renderer_if.sv
// Signal bundle between the board renderer, the board RAM read port and the VGA plot interface.
// The renderer takes the slave side. The controller, RAM and VGA side takes the master side.
interface board_renderer_if;
  logic       start;
  logic [2:0] cursor_x;
  logic [2:0] cursor_y;
  logic       cursor_en;
  logic [2:0] mem_x;
  logic [2:0] mem_y;
  logic [3:0] mem_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       render_complete;

  modport master (
    output start, cursor_x, cursor_y, cursor_en, mem_data,
    input  mem_x, mem_y, vga_x, vga_y, vga_colour, plot, busy, render_complete
  );

  modport slave (
    input  start, cursor_x, cursor_y, cursor_en, mem_data,
    output mem_x, mem_y, vga_x, vga_y, vga_colour, plot, busy, render_complete
  );
endinterface

// File: rtl/board_renderer.sv
// Walks the 8x8 board RAM and draws each square as an 8x8 tile on the VGA plot interface.
// Each tile gets a square colour, a piece glyph and an optional cursor border.
module board_renderer #(
  parameter logic [7:0] X_OFFSET      = 8'd48,
  parameter logic [6:0] Y_OFFSET      = 7'd28,
  parameter logic [2:0] LIGHT_COLOUR  = 3'b010,
  parameter logic [2:0] DARK_COLOUR   = 3'b001,
  parameter logic [2:0] CURSOR_COLOUR = 3'b110
) (
  input  logic             clk,
  input  logic             reset,
  board_renderer_if.slave  bus
);

  localparam logic [2:0] BLACK_GLYPH = 3'b100;
  localparam logic [2:0] WHITE_GLYPH = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [2:0] r_sq_x;
  logic [2:0] r_sq_y;
  logic [2:0] r_px;
  logic [2:0] r_py;
  logic [3:0] r_piece;
  logic       r_plot;
  logic       r_busy;
  logic       r_done;

  logic [5:0] w_pix_idx;
  logic       w_pix_last;
  logic       w_draw;
  logic       w_border;
  logic       w_cursor_hit;
  logic       w_glyph_area;
  logic       w_glyph_hit;
  logic [2:0] w_glyph_colour;
  logic [2:0] w_square_colour;
  logic [2:0] w_pixel_colour;

  assign w_pix_idx  = {r_py, r_px};
  assign w_pix_last = &w_pix_idx;

  // Address stays on the current square from S_NEXT onwards, so the RAM sees it in S_READ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sq_x  <= 3'd0;
      r_sq_y  <= 3'd0;
      r_px    <= 3'd0;
      r_py    <= 3'd0;
      r_piece <= 4'd0;
      r_plot  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_READ;
            r_busy  <= 1'b1;
          end
        end

        S_READ: begin
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          r_piece <= bus.mem_data;
          r_plot  <= 1'b1;
          r_state <= S_DRAW;
        end

        S_DRAW: begin
          {r_py, r_px} <= w_pix_idx + 6'd1;
          if (w_pix_last) begin
            r_plot  <= 1'b0;
            r_state <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (r_sq_x == 3'd7 && r_sq_y == 3'd7) begin
            r_sq_x  <= 3'd0;
            r_sq_y  <= 3'd0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (r_sq_x == 3'd7) begin
              r_sq_x <= 3'd0;
              r_sq_y <= r_sq_y + 3'd1;
            end else begin
              r_sq_x <= r_sq_x + 3'd1;
            end
            r_state <= S_READ;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_plot  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign w_draw = (r_state == S_DRAW);

  // Cursor inputs are used live, so a moved cursor only affects tiles not yet drawn.
  assign w_border     = (r_px == 3'd0) || (r_px == 3'd7) || (r_py == 3'd0) || (r_py == 3'd7);
  assign w_cursor_hit = bus.cursor_en && (r_sq_x == bus.cursor_x) &&
                        (r_sq_y == bus.cursor_y) && w_border;

  // Codes 0 and 13..15 are not pieces and fall through to the plain square colour.
  assign w_glyph_area   = (r_px >= 3'd2) && (r_px <= 3'd5) && (r_py >= 3'd2) && (r_py <= 3'd5);
  assign w_glyph_hit    = (r_piece >= 4'd1) && (r_piece <= 4'd12) && w_glyph_area;
  assign w_glyph_colour = (r_piece <= 4'd6) ? BLACK_GLYPH : WHITE_GLYPH;

  assign w_square_colour = (r_sq_x[0] ^ r_sq_y[0]) ? DARK_COLOUR : LIGHT_COLOUR;

  always_comb begin
    w_pixel_colour = w_square_colour;
    if (w_cursor_hit) begin
      w_pixel_colour = CURSOR_COLOUR;
    end else if (w_glyph_hit) begin
      w_pixel_colour = w_glyph_colour;
    end
  end

  assign bus.mem_x           = r_sq_x;
  assign bus.mem_y           = r_sq_y;
  assign bus.vga_x           = w_draw ? (X_OFFSET + {2'b00, r_sq_x, r_px}) : 8'd0;
  assign bus.vga_y           = w_draw ? (Y_OFFSET + {1'b0, r_sq_y, r_py}) : 7'd0;
  assign bus.vga_colour      = w_draw ? w_pixel_colour : 3'd0;
  assign bus.plot            = r_plot;
  assign bus.busy            = r_busy;
  assign bus.render_complete = r_done;

endmodule
